// File: rtl/wrr_grant_scheduler.sv
// wrr_grant_scheduler
//
// Weighted round-robin arbiter for NUM_CLIENTS requesters sharing one
// resource. A granted client keeps the grant for a tenure of up to
// weight[i] cycles (weight 0 counts as 1). The tenure ends early if the
// owner drops its request. At a tenure end the next owner is chosen in
// the same edge, so there is no idle cycle between back-to-back grants.
//
// Ports
//   clk          single clock, rising edge
//   rst          synchronous, active-high reset
//   req          per-client level request
//   weight       client i weight in [i*WEIGHT_W +: WEIGHT_W], sampled at tenure start
//   grant        registered one-hot (or zero) grant
//   grant_valid  |grant, registered
//   grant_idx    index of the granted client, 0 when idle
//   credit       cycles left in the current tenure including this one, 0 when idle
//
// Handshake: req is a level held by the client while it wants the
// resource; grant[i] high means client i owns the resource this cycle.
// There is no separate accept, so a grant seen with req low is simply
// released at the next edge.

module wrr_grant_scheduler #(
    parameter int NUM_CLIENTS = 4,
    parameter int WEIGHT_W    = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_CLIENTS-1:0]          req,
    input  logic [NUM_CLIENTS*WEIGHT_W-1:0] weight,
    output logic [NUM_CLIENTS-1:0]          grant,
    output logic                            grant_valid,
    output logic [$clog2(NUM_CLIENTS)-1:0]  grant_idx,
    output logic [WEIGHT_W-1:0]             credit
);

    localparam int IDX_W = $clog2(NUM_CLIENTS);
    // One extra bit so ptr + offset cannot overflow before the wrap.
    localparam int CW    = IDX_W + 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] OWNED = 1'b1;

    logic [0:0]          state;
    logic [IDX_W-1:0]    ptr;

    logic [WEIGHT_W-1:0] wt [NUM_CLIENTS];

    logic                owner_req;
    logic                tenure_end;
    logic [IDX_W-1:0]    after_owner;
    logic [IDX_W-1:0]    arb_start;
    logic [CW-1:0]       cand;
    logic                win_found;
    logic [IDX_W-1:0]    win_idx;
    logic [WEIGHT_W-1:0] fresh_credit;

    for (genvar g = 0; g < NUM_CLIENTS; g++) begin : g_wt
        assign wt[g] = weight[g*WEIGHT_W +: WEIGHT_W];
    end

    assign owner_req   = req[grant_idx];
    assign tenure_end  = (state == OWNED) && (!owner_req || (credit == WEIGHT_W'(1)));
    assign after_owner = (grant_idx == IDX_W'(NUM_CLIENTS - 1)) ? '0 : grant_idx + 1'b1;

    // While OWNED the only arbitration that matters is the one at tenure
    // end, which searches from owner+1 -- the same value ptr takes at that
    // edge. In IDLE the stored ptr is used.
    assign arb_start = (state == OWNED) ? after_owner : ptr;

    // First set request at arb_start, arb_start+1, ... modulo NUM_CLIENTS.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            cand = CW'(arb_start) + CW'(i);
            if (cand >= CW'(NUM_CLIENTS)) begin
                cand = cand - CW'(NUM_CLIENTS);
            end
            if (!win_found && req[cand[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDX_W-1:0];
            end
        end
    end

    assign fresh_credit = (wt[win_idx] == '0) ? WEIGHT_W'(1) : wt[win_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_idx   <= '0;
            credit      <= '0;
        end else if ((state == IDLE) || tenure_end) begin
            if (tenure_end) begin
                ptr <= after_owner;
            end
            if (win_found) begin
                state       <= OWNED;
                grant       <= NUM_CLIENTS'(1) << win_idx;
                grant_valid <= 1'b1;
                grant_idx   <= win_idx;
                credit      <= fresh_credit;
            end else begin
                state       <= IDLE;
                grant       <= '0;
                grant_valid <= 1'b0;
                grant_idx   <= '0;
                credit      <= '0;
            end
        end else begin
            // Tenure continues: grant held, other requests ignored.
            credit <= credit - WEIGHT_W'(1);
        end
    end

endmodule
